hwpe_stream_fsm: RTL and testbench

HWPE_STREAM_FSM -- requirements
Module: hwpe_stream_fsm

---
 rtl/hwpe_stream_fsm.sv | 169 ++++++++++++++++
 tb/tb_hwpe_stream_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_fsm.sv
// Job sequencer for a streaming accelerator: launches the source/sink streamers and the
// engine, counts iterations, hands control to the microcode between iterations.
`timescale 1ns/1ps

module hwpe_stream_fsm #(
   parameter int unsigned NB_SOURCE = 3,
   parameter int unsigned NB_SINK   = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [CNT_W-1:0]     len_i,
   input  logic [NB_SOURCE-1:0] src_mask_i,
   input  logic [NB_SINK-1:0]   sink_mask_i,
   input  logic [NB_SOURCE-1:0] src_ready_start_i,
   input  logic [NB_SINK-1:0]   sink_ready_start_i,
   output logic [NB_SOURCE-1:0] src_req_start_o,
   output logic [NB_SINK-1:0]   sink_req_start_o,
   input  logic [CNT_W-1:0]     engine_cnt_i,
   output logic                 engine_start_o,
   output logic                 engine_clear_o,
   output logic                 engine_enable_o,
   output logic                 ucode_enable_o,
   output logic                 ucode_clear_o,
   input  logic                 ucode_valid_i,
   input  logic                 ucode_done_i,
   output logic                 done_o,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     iter_o
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      COMPUTE,
      UPDATEIDX,
      WAIT,
      TERMINATE
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       len_reg;
   logic [CNT_W-1:0]       iter_reg;
   logic [NB_SOURCE-1:0]   src_mask_reg;
   logic [NB_SINK-1:0]     sink_mask_reg;
   logic [NB_SOURCE-1:0]   src_ok;
   logic [NB_SINK-1:0]     sink_ok;
   logic                   rdy;
   logic                   launch;
   logic                   iter_inc;
   logic                   job_start;

   // A stream that is not used by this job never holds back a launch.
   for (genvar gi = 0; gi < NB_SOURCE; gi++) begin : g_src
      assign src_ok[gi]          = src_ready_start_i[gi] | ~src_mask_reg[gi];
      assign src_req_start_o[gi] = launch & src_mask_reg[gi];
   end

   for (genvar gi = 0; gi < NB_SINK; gi++) begin : g_sink
      assign sink_ok[gi]          = sink_ready_start_i[gi] | ~sink_mask_reg[gi];
      assign sink_req_start_o[gi] = launch & sink_mask_reg[gi];
   end

   assign rdy            = (&src_ok) & (&sink_ok);
   assign engine_start_o = launch;
   assign busy_o         = (state_reg != IDLE);
   assign iter_o         = iter_reg;

   always_comb begin
      state_next      = state_reg;
      launch          = 1'b0;
      iter_inc        = 1'b0;
      job_start       = 1'b0;
      engine_clear_o  = 1'b1;
      engine_enable_o = 1'b1;
      ucode_enable_o  = 1'b0;
      ucode_clear_o   = 1'b0;
      done_o          = 1'b0;

      unique case (state_reg)
         IDLE: begin
            ucode_clear_o = 1'b1;
            if (start_i) begin
               job_start  = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (rdy) begin
               launch     = 1'b1;
               state_next = COMPUTE;
            end else begin
               state_next = WAIT;
            end
         end
         COMPUTE: begin
            engine_clear_o = 1'b0;
            if (engine_cnt_i == len_reg) begin
               iter_inc   = 1'b1;
               state_next = UPDATEIDX;
            end
         end
         UPDATEIDX: begin
            if (!ucode_valid_i) begin
               ucode_enable_o = 1'b1;
            end else if (ucode_done_i) begin
               state_next = TERMINATE;
            end else if (rdy) begin
               launch     = 1'b1;
               state_next = COMPUTE;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            engine_clear_o  = 1'b0;
            engine_enable_o = 1'b0;
            if (rdy) begin
               launch     = 1'b1;
               state_next = COMPUTE;
            end
         end
         TERMINATE: begin
            engine_clear_o  = 1'b0;
            engine_enable_o = 1'b0;
            if (rdy) begin
               done_o     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Launch overrides whatever engine controls the current state would otherwise show.
      if (launch) begin
         engine_clear_o  = 1'b0;
         engine_enable_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         iter_reg      <= '0;
         src_mask_reg  <= '0;
         sink_mask_reg <= '0;
      end else if (clear_i) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         iter_reg      <= '0;
         src_mask_reg  <= '0;
         sink_mask_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (job_start) begin
            len_reg       <= len_i;
            src_mask_reg  <= src_mask_i;
            sink_mask_reg <= sink_mask_i;
            iter_reg      <= '0;
         end else if (iter_inc) begin
            iter_reg <= iter_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hwpe_stream_fsm.sv
// Directed bench for hwpe_stream_fsm: a job-level reference model checked every cycle,
// plus per-job literal tallies (launches, done pulses, compute cycles, stalls).
`timescale 1ns/1ps

module tb_hwpe_stream_fsm;
   localparam int NS = 3;
   localparam int NK = 1;
   localparam int CW = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic          start_i = 1'b0;
   logic [CW-1:0] len_i = '0;
   logic [NS-1:0] src_mask_i = '0;
   logic [NK-1:0] sink_mask_i = '0;
   logic [NS-1:0] src_ready_start_i = '1;
   logic [NK-1:0] sink_ready_start_i = '1;
   logic [NS-1:0] src_req_start_o;
   logic [NK-1:0] sink_req_start_o;
   logic [CW-1:0] engine_cnt_i = '0;
   logic          engine_start_o, engine_clear_o, engine_enable_o;
   logic          ucode_enable_o, ucode_clear_o;
   logic          ucode_valid_i = 1'b1;
   logic          ucode_done_i = 1'b0;
   logic          done_o, busy_o;
   logic [CW-1:0] iter_o;

   hwpe_stream_fsm #(.NB_SOURCE(NS), .NB_SINK(NK), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .len_i(len_i), .src_mask_i(src_mask_i), .sink_mask_i(sink_mask_i),
      .src_ready_start_i(src_ready_start_i), .sink_ready_start_i(sink_ready_start_i),
      .src_req_start_o(src_req_start_o), .sink_req_start_o(sink_req_start_o),
      .engine_cnt_i(engine_cnt_i), .engine_start_o(engine_start_o),
      .engine_clear_o(engine_clear_o), .engine_enable_o(engine_enable_o),
      .ucode_enable_o(ucode_enable_o), .ucode_clear_o(ucode_clear_o),
      .ucode_valid_i(ucode_valid_i), .ucode_done_i(ucode_done_i),
      .done_o(done_o), .busy_o(busy_o), .iter_o(iter_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [NS-1:0] sreq;
      logic [NK-1:0] kreq;
      logic          est, eclr, een, uen, uclr, done, busy;
      logic [CW-1:0] iter;
   } outs_t;

   int n_vec = 0;
   int n_err = 0;

   // Job phases of the reference model: what the job is doing, not how the DUT encodes it.
   localparam int PH_IDLE = 0, PH_START = 1, PH_RUN = 2, PH_IDX = 3, PH_HOLD = 4, PH_FIN = 5;
   int            ph = PH_IDLE;
   logic [CW-1:0] m_len = '0;
   logic [CW-1:0] m_iter = '0;
   logic [NS-1:0] m_src = '0;
   logic [NK-1:0] m_snk = '0;

   function automatic logic model_rdy();
      return ((src_ready_start_i | ~m_src) == '1) && ((sink_ready_start_i | ~m_snk) == '1);
   endfunction

   task automatic model_reset();
      ph = PH_IDLE; m_len = '0; m_iter = '0; m_src = '0; m_snk = '0;
   endtask

   function automatic outs_t model_outs();
      outs_t o;
      logic  go;
      o = '0;
      o.eclr = 1'b1;
      o.een  = 1'b1;
      o.busy = (ph != PH_IDLE);
      o.iter = m_iter;
      go = model_rdy() && (ph == PH_START || ph == PH_HOLD ||
                           (ph == PH_IDX && ucode_valid_i && !ucode_done_i));
      if (ph == PH_IDLE) o.uclr = 1'b1;
      if (ph == PH_RUN) o.eclr = 1'b0;
      if (ph == PH_IDX) o.uen = !ucode_valid_i;
      if (ph == PH_HOLD || ph == PH_FIN) begin o.eclr = 1'b0; o.een = 1'b0; end
      if (go) begin
         o.est = 1'b1; o.eclr = 1'b0; o.een = 1'b1; o.sreq = m_src; o.kreq = m_snk;
      end
      o.done = (ph == PH_FIN) && model_rdy();
      return o;
   endfunction

   task automatic model_step();
      logic r;
      r = model_rdy();
      if (!rst_ni || clear_i) begin
         model_reset();
      end else begin
         case (ph)
            PH_IDLE:  if (start_i) begin
                         m_len = len_i; m_src = src_mask_i; m_snk = sink_mask_i;
                         m_iter = '0; ph = PH_START;
                      end
            PH_START: ph = r ? PH_RUN : PH_HOLD;
            PH_RUN:   if (engine_cnt_i == m_len) begin m_iter = m_iter + CW'(1); ph = PH_IDX; end
            PH_IDX:   if (ucode_valid_i) ph = ucode_done_i ? PH_FIN : (r ? PH_RUN : PH_HOLD);
            PH_HOLD:  if (r) ph = PH_RUN;
            PH_FIN:   if (r) ph = PH_IDLE;
            default:  ph = PH_IDLE;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      model_step();
   end

   // Per-job tallies of what the DUT actually did.
   int    launches, done_cnt, comp_cnt, en0_cnt;
   logic [NS-1:0] src_or, src_and;
   logic [NK-1:0] snk_or;
   outs_t exp_o, act_o, last_act;

   initial forever begin
      @(negedge clk_i);
      if (!rst_ni) model_reset();
      exp_o = model_outs();
      act_o = {src_req_start_o, sink_req_start_o, engine_start_o, engine_clear_o,
               engine_enable_o, ucode_enable_o, ucode_clear_o, done_o, busy_o, iter_o};
      n_vec++;
      if (act_o !== exp_o) begin
         n_err++;
         $display("FAIL outputs @%0t: got %h, expected %h", $time, act_o, exp_o);
      end
      if (act_o.est) begin
         launches++; src_or |= act_o.sreq; src_and &= act_o.sreq; snk_or |= act_o.kreq;
      end
      if (act_o.done) done_cnt++;
      if (!act_o.est && !act_o.eclr && act_o.een) comp_cnt++;
      if (!act_o.een && !act_o.done) en0_cnt++;
      last_act = act_o;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Stimulus policy knobs.
   int            target_iter, stall_left;
   logic          uv_toggle, stall_en, stall_used, hold_low, noisy_start;
   logic          rst_at3, clr_in_wait, mid_change;
   logic [NS-1:0] src_rdy_val;
   logic [NK-1:0] snk_rdy_val;

   task automatic reset_policy();
      target_iter = 2; stall_left = 0;
      uv_toggle = 0; stall_en = 0; stall_used = 0; hold_low = 0; noisy_start = 0;
      rst_at3 = 0; clr_in_wait = 0; mid_change = 0;
      src_rdy_val = '1; snk_rdy_val = '1; ucode_valid_i = 1'b1;
   endtask

   task automatic apply_policy();
      ucode_done_i  = (int'(m_iter) >= target_iter);
      ucode_valid_i = uv_toggle ? ~ucode_valid_i : 1'b1;
      if (stall_en && !stall_used && ph == PH_IDX && int'(m_iter) == 1) begin
         stall_left = 6; stall_used = 1'b1;
      end
      src_ready_start_i  = hold_low ? '0 : src_rdy_val;
      sink_ready_start_i = (stall_left > 0 || hold_low) ? '0 : snk_rdy_val;
      if (stall_left > 0) stall_left--;
      start_i = noisy_start && (ph == PH_RUN);
      clear_i = clr_in_wait && (ph == PH_HOLD);
   endtask

   // Advance one clock; the engine counter restarts on a launch and counts while enabled.
   task automatic cycle();
      @(posedge clk_i);
      #1;
      if (last_act.est) engine_cnt_i = '0;
      else if (last_act.een && !last_act.eclr) engine_cnt_i = engine_cnt_i + CW'(1);
   endtask

   task automatic run_job(input string name, input logic [CW-1:0] len,
                          input logic [NS-1:0] sm, input logic [NK-1:0] km);
      logic finished;
      finished = 1'b0;
      launches = 0; done_cnt = 0; comp_cnt = 0; en0_cnt = 0;
      src_or = '0; src_and = '1; snk_or = '0;
      apply_policy();
      len_i = len; src_mask_i = sm; sink_mask_i = km; start_i = 1'b1;
      cycle();
      start_i = 1'b0;
      if (mid_change) begin
         len_i = len + CW'(3); src_mask_i = ~sm; sink_mask_i = ~km;
      end
      for (int c = 0; c < 400; c++) begin
         if (ph == PH_IDLE) begin finished = 1'b1; break; end
         apply_policy();
         if (rst_at3 && ph == PH_RUN && int'(m_iter) == 3) begin
            check({name, "_iter_before_rst"}, 64'(iter_o), 64'd3);
            rst_ni = 1'b0;
            #1;
            check({name, "_rst_busy"}, 64'(busy_o), 64'd0);
            check({name, "_rst_iter"}, 64'(iter_o), 64'd0);
            check({name, "_rst_ctl"}, 64'({engine_clear_o, engine_enable_o, ucode_clear_o}), 64'd7);
            @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
            finished = 1'b1;
            break;
         end
         cycle();
      end
      if (!finished) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: job still active after 400 cycles, expected IDLE", name);
      end
      clear_i = 1'b0; start_i = 1'b0;
      @(negedge clk_i);
      $display("job %-10s launches=%0d done=%0d compute=%0d stall=%0d iter=%0d",
               name, launches, done_cnt, comp_cnt, en0_cnt, iter_o);
   endtask

   task automatic realign();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_policy();
      @(negedge clk_i);
      check("reset_ctl", 64'({engine_clear_o, engine_enable_o, ucode_clear_o}), 64'd7);
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_strobes", 64'({src_req_start_o, sink_req_start_o, engine_start_o,
                                   ucode_enable_o, done_o}), 64'd0);
      realign();
      rst_ni = 1'b1;
      realign();

      reset_policy();
      run_job("basic", CW'(4), 3'b111, 1'b1);
      check("basic_launches", 64'(launches), 64'd2);
      check("basic_src_req", 64'({src_or, src_and}), 64'h3f);
      check("basic_sink_req", 64'(snk_or), 64'd1);
      check("basic_iter", 64'(iter_o), 64'd2);
      check("basic_done", 64'(done_cnt), 64'd1);
      check("basic_compute", 64'(comp_cnt), 64'd10);
      realign();

      reset_policy();
      target_iter = 3; src_rdy_val = 3'b011;
      run_job("mask011", CW'(2), 3'b011, 1'b1);
      check("mask_launches", 64'(launches), 64'd3);
      check("mask_src_req", 64'({src_or, src_and}), 64'h1b);
      check("mask_iter", 64'(iter_o), 64'd3);
      check("mask_done", 64'(done_cnt), 64'd1);
      realign();

      reset_policy();
      stall_en = 1'b1;
      run_job("stall", CW'(1), 3'b111, 1'b1);
      check("stall_enable_low", 64'(en0_cnt), 64'd5);
      check("stall_launches", 64'(launches), 64'd2);
      check("stall_done", 64'(done_cnt), 64'd1);
      realign();

      reset_policy();
      run_job("len0", CW'(0), 3'b111, 1'b1);
      check("len0_compute", 64'(comp_cnt), 64'd2);
      check("len0_done", 64'(done_cnt), 64'd1);
      check("len0_iter", 64'(iter_o), 64'd2);
      realign();

      reset_policy();
      mid_change = 1'b1;
      run_job("midchange", CW'(2), 3'b101, 1'b1);
      check("mid_src_req", 64'({src_or, src_and}), 64'h2d);
      check("mid_compute", 64'(comp_cnt), 64'd6);
      check("mid_launches", 64'(launches), 64'd2);
      realign();

      reset_policy();
      src_rdy_val = '0; snk_rdy_val = '0;
      run_job("zeromask", CW'(1), 3'b000, 1'b0);
      check("zero_launches", 64'(launches), 64'd2);
      check("zero_req", 64'({src_or, snk_or}), 64'd0);
      check("zero_done", 64'(done_cnt), 64'd1);
      realign();

      reset_policy();
      uv_toggle = 1'b1; noisy_start = 1'b1;
      run_job("ucode", CW'(1), 3'b110, 1'b1);
      check("ucode_done", 64'(done_cnt), 64'd1);
      check("ucode_iter", 64'(iter_o), 64'd2);
      check("ucode_launches", 64'(launches), 64'd2);
      realign();

      reset_policy();
      target_iter = 100; rst_at3 = 1'b1;
      run_job("rst_iter3", CW'(1), 3'b111, 1'b1);
      check("rst_done", 64'(done_cnt), 64'd0);
      check("rst_iter_after", 64'(iter_o), 64'd0);
      realign();

      reset_policy();
      hold_low = 1'b1; clr_in_wait = 1'b1;
      run_job("clr_wait", CW'(1), 3'b111, 1'b1);
      check("clr_done", 64'(done_cnt), 64'd0);
      check("clr_launches", 64'(launches), 64'd0);
      check("clr_busy", 64'(busy_o), 64'd0);
      realign();

      reset_policy();
      start_i = 1'b1; clear_i = 1'b1; len_i = CW'(1);
      cycle();
      start_i = 1'b0; clear_i = 1'b0;
      @(negedge clk_i);
      check("clear_over_start_busy", 64'(busy_o), 64'd0);
      $display("job %-10s busy=%0d", "clr_start", busy_o);
      realign();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
